// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake on both sides, registered result and flags.
// Shifts run one bit per cycle; all other ops complete in a single cycle.
module alu_seq #(
   parameter int WIDTH    = 8,
   parameter int OP_WIDTH = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] alu_op,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out,
   output logic                flag_z,
   output logic                flag_n,
   output logic                flag_c,
   output logic                flag_v,
   output logic                illegal_op
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);

   localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_NAND = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SHL  = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_SHR  = OP_WIDTH'(8);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] cnt;
   logic             shift_left;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_ill;
   logic             is_shift;
   logic [CNT_W-1:0] shift_cnt;
   logic [WIDTH-1:0] step_res;
   logic             step_c;

   assign in_ready = (state == IDLE);

   // Single-cycle datapath; a zero-length shift passes operand A straight through.
   always_comb begin
      sum       = {1'b0, in_a} + {1'b0, in_b};
      diff      = {1'b0, in_a} - {1'b0, in_b};
      alu_res   = '0;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      alu_ill   = 1'b0;
      is_shift  = 1'b0;
      shift_cnt = (in_b >= WIDTH_VAL) ? CNT_MAX : CNT_W'(in_b);
      case (alu_op)
         OP_OR:   alu_res = in_a | in_b;
         OP_NAND: alu_res = ~(in_a & in_b);
         OP_NOR:  alu_res = ~(in_a | in_b);
         OP_AND:  alu_res = in_a & in_b;
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SHL, OP_SHR: begin
            alu_res  = in_a;
            is_shift = 1'b1;
         end
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      step_res = shift_left ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
      step_c   = shift_left ? shift_reg[WIDTH-1] : shift_reg[0];
   end

   // Outputs are written only on entry to DONE so they stay frozen during SHIFT and backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_reg  <= '0;
         cnt        <= '0;
         shift_left <= 1'b0;
         out        <= '0;
         flag_z     <= 1'b0;
         flag_n     <= 1'b0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
         illegal_op <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift && (shift_cnt != '0)) begin
                     shift_reg  <= in_a;
                     cnt        <= shift_cnt;
                     shift_left <= (alu_op == OP_SHL);
                     state      <= SHIFT;
                  end else begin
                     out        <= alu_res;
                     flag_z     <= (alu_res == '0);
                     flag_n     <= alu_res[WIDTH-1];
                     flag_c     <= alu_c;
                     flag_v     <= alu_v;
                     illegal_op <= alu_ill;
                     out_valid  <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            SHIFT: begin
               shift_reg <= step_res;
               cnt       <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  out        <= step_res;
                  flag_z     <= (step_res == '0);
                  flag_n     <= step_res[WIDTH-1];
                  flag_c     <= step_c;
                  flag_v     <= 1'b0;
                  illegal_op <= 1'b0;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
